// File: rtl/packet_rx_fifo.sv
// Store-and-forward RX packet FIFO: a data RAM with a speculative write pointer plus a
// metadata FIFO. Frames become visible only when a clean commit pushes their {len, meta}.
module packet_rx_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DATA_DEPTH = 1024,
    parameter int META_DEPTH = 64,
    parameter int META_WIDTH = 64,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518,
    localparam int BW = $clog2(DATA_WIDTH / 8) + 1,
    localparam int AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BW-1:0]         wr_bytes,
    input  logic                  wr_commit,
    input  logic                  wr_drop,
    input  logic [META_WIDTH-1:0] wr_meta,
    output logic                  rd_meta_valid,
    output logic [META_WIDTH-1:0] rd_meta,
    output logic [13:0]           rd_len,
    input  logic                  rd_fwd_en,
    input  logic                  rd_pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [BW-1:0]         rd_bytes,
    output logic                  rd_last,
    output logic [AW:0]           free_words,
    output logic                  ev_queued,
    output logic                  ev_drop_fifo,
    output logic                  ev_drop_runt,
    output logic                  ev_drop_jumbo
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = AW + 1;
    localparam int MW    = $clog2(META_DEPTH);
    localparam int MCW   = MW + 1;
    localparam int EW    = 14 + META_WIDTH;
    localparam logic [13:0] MIN_L = 14'(MIN_FRAME);
    localparam logic [13:0] MAX_L = 14'(MAX_FRAME);

    typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DISCARD} wr_state_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
    logic [13:0]    len_q, len_d;
    logic [MW-1:0]  meta_wp_q, meta_wp_d, meta_rp_q, meta_rp_d;
    logic [MCW-1:0] meta_cnt_q, meta_cnt_d;
    logic [PW-1:0]  free_q, free_d;
    logic           rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [BW-1:0]  rd_bytes_q, rd_bytes_d;
    logic           ev_queued_q, ev_queued_d, ev_fifo_q, ev_fifo_d;
    logic           ev_runt_q, ev_runt_d, ev_jumbo_q, ev_jumbo_d;

    logic [DATA_WIDTH-1:0] data_mem [DATA_DEPTH];
    logic [EW-1:0]         meta_mem [META_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata_q;

    logic          ram_we, ram_re, meta_push, meta_pop;
    logic [AW-1:0] ram_raddr;

    // Effective length/pointer including a word that arrives alongside wr_commit.
    logic          data_full, meta_full, accept, ovf;
    logic [14:0]   len_sum;
    logic [13:0]   len_eff;
    logic [PW-1:0] tmp_eff;

    assign data_full = (wr_tmp_q - rd_ptr_q) == PW'(DATA_DEPTH);
    assign meta_full = meta_cnt_q == MCW'(META_DEPTH);
    assign accept    = wr_valid && !data_full;
    assign ovf       = wr_valid && data_full;
    assign len_sum   = {1'b0, len_q} + 15'(wr_bytes);
    assign len_eff   = !accept ? len_q : (len_sum[14] ? 14'h3FFF : len_sum[13:0]);
    assign tmp_eff   = accept ? wr_tmp_q + PW'(1) : wr_tmp_q;

    logic          head_valid;
    logic [EW-1:0] head_entry;
    logic [13:0]   head_len, head_words, head_rem;
    logic [PW-1:0] head_words_pw;
    logic [BW-1:0] last_bytes;

    assign head_valid    = meta_cnt_q != '0;
    assign head_entry    = meta_mem[meta_rp_q];
    assign head_len      = head_entry[EW-1:META_WIDTH];
    assign head_words    = 14'((15'(head_len) + 15'(BYTES - 1)) / 15'(BYTES));
    assign head_rem      = 14'(head_len % 14'(BYTES));
    assign head_words_pw = PW'(head_words);
    assign last_bytes    = (head_rem == '0) ? BW'(BYTES) : BW'(head_rem);

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_tmp_d    = wr_tmp_q;
        wr_ptr_d    = wr_ptr_q;
        len_d       = len_q;
        ram_we      = 1'b0;
        meta_push   = 1'b0;
        ev_queued_d = 1'b0;
        ev_fifo_d   = 1'b0;
        ev_runt_d   = 1'b0;
        ev_jumbo_d  = 1'b0;
        if (wr_start) begin
            wr_tmp_d   = wr_ptr_q;
            len_d      = '0;
            wr_state_d = WR_ACTIVE;
        end else begin
            case (wr_state_q)
                WR_ACTIVE: begin
                    ram_we = accept;
                    if (wr_drop) begin
                        wr_tmp_d   = wr_ptr_q;
                        wr_state_d = WR_IDLE;
                    end else if (wr_commit) begin
                        wr_tmp_d   = wr_ptr_q;
                        wr_state_d = WR_IDLE;
                        if (ovf || meta_full) begin
                            ev_fifo_d = 1'b1;
                        end else if (len_eff < MIN_L) begin
                            ev_runt_d = 1'b1;
                        end else if (len_eff > MAX_L) begin
                            ev_jumbo_d = 1'b1;
                        end else begin
                            meta_push   = 1'b1;
                            wr_ptr_d    = tmp_eff;
                            wr_tmp_d    = tmp_eff;
                            ev_queued_d = 1'b1;
                        end
                    end else begin
                        wr_tmp_d = tmp_eff;
                        len_d    = len_eff;
                        if (ovf) begin
                            wr_state_d = WR_DISCARD;
                        end
                    end
                end
                WR_DISCARD: begin
                    if (wr_drop || wr_commit) begin
                        wr_tmp_d   = wr_ptr_q;
                        wr_state_d = WR_IDLE;
                        ev_fifo_d  = !wr_drop;
                    end
                end
                default: ;
            endcase
        end
    end

    // The head frame is released in the cycle rd_last is shown, so the next fwd is accepted the cycle after.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_bytes_d = '0;
        ram_re     = 1'b0;
        ram_raddr  = AW'(rd_ptr_q + rd_cnt_q);
        meta_pop   = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (head_valid && rd_pop) begin
                    meta_pop = 1'b1;
                    rd_ptr_d = rd_ptr_q + head_words_pw;
                end else if (head_valid && rd_fwd_en) begin
                    rd_state_d = RD_STREAM;
                    rd_cnt_d   = '0;
                end
            end
            RD_STREAM: begin
                if (rd_last_q) begin
                    meta_pop   = 1'b1;
                    rd_ptr_d   = rd_ptr_q + head_words_pw;
                    rd_state_d = RD_IDLE;
                end else if (rd_cnt_q != head_words_pw) begin
                    ram_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_cnt_q + PW'(1)) == head_words_pw;
                    rd_bytes_d = rd_last_d ? last_bytes : BW'(BYTES);
                    rd_cnt_d   = rd_cnt_q + PW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        meta_cnt_d = meta_cnt_q + MCW'(meta_push) - MCW'(meta_pop);
        meta_wp_d  = meta_push ? meta_wp_q + MW'(1) : meta_wp_q;
        meta_rp_d  = meta_pop ? meta_rp_q + MW'(1) : meta_rp_q;
        free_d     = PW'(DATA_DEPTH) - (wr_tmp_d - rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= WR_IDLE;
            rd_state_q  <= RD_IDLE;
            wr_ptr_q    <= '0;
            wr_tmp_q    <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            len_q       <= '0;
            meta_wp_q   <= '0;
            meta_rp_q   <= '0;
            meta_cnt_q  <= '0;
            free_q      <= PW'(DATA_DEPTH);
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_bytes_q  <= '0;
            ev_queued_q <= 1'b0;
            ev_fifo_q   <= 1'b0;
            ev_runt_q   <= 1'b0;
            ev_jumbo_q  <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_tmp_q    <= wr_tmp_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            len_q       <= len_d;
            meta_wp_q   <= meta_wp_d;
            meta_rp_q   <= meta_rp_d;
            meta_cnt_q  <= meta_cnt_d;
            free_q      <= free_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_bytes_q  <= rd_bytes_d;
            ev_queued_q <= ev_queued_d;
            ev_fifo_q   <= ev_fifo_d;
            ev_runt_q   <= ev_runt_d;
            ev_jumbo_q  <= ev_jumbo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            data_mem[wr_tmp_q[AW-1:0]] <= wr_data;
        end
        if (ram_re) begin
            ram_rdata_q <= data_mem[ram_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (meta_push) begin
            meta_mem[meta_wp_q] <= {len_eff, wr_meta};
        end
    end

    // Memory contents are not reset, so everything read from them is gated by its valid.
    assign rd_meta_valid = head_valid;
    assign rd_meta       = head_valid ? head_entry[META_WIDTH-1:0] : '0;
    assign rd_len        = head_valid ? head_len : '0;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_valid_q ? ram_rdata_q : '0;
    assign rd_bytes      = rd_bytes_q;
    assign rd_last       = rd_last_q;
    assign free_words    = free_q;
    assign ev_queued     = ev_queued_q;
    assign ev_drop_fifo  = ev_fifo_q;
    assign ev_drop_runt  = ev_runt_q;
    assign ev_drop_jumbo = ev_jumbo_q;

endmodule
